// File: rtl/id_scoreboard_if.sv
// Decode-stage issue bundle: instruction operands, writeback clears and scoreboard verdict.
// Outputs are combinational from registered state; no internal backpressure.
interface id_scoreboard_if #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int MAX_LAT  = 3,
  parameter int MAX_VAR  = 2
);
  localparam int LAT_W = $clog2(MAX_LAT + 1);
  localparam int VC_W  = $clog2(MAX_VAR + 1);

  logic                id_valid_i;
  logic [REG_AW-1:0]   id_rs1_i;
  logic [REG_AW-1:0]   id_rs2_i;
  logic                id_use_rs1_i;
  logic                id_use_rs2_i;
  logic [REG_AW-1:0]   id_rd_i;
  logic                id_wen_i;
  logic [LAT_W-1:0]    id_lat_i;
  logic                id_var_i;
  logic                flush_i;
  logic                wb_clr_i;
  logic [REG_AW-1:0]   wb_rd_i;
  logic                stall_o;
  logic                issue_o;
  logic [NUM_REGS-1:0] busy_o;
  logic [VC_W-1:0]     var_cnt_o;

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
           id_rd_i, id_wen_i, id_lat_i, id_var_i, flush_i, wb_clr_i, wb_rd_i,
    input  stall_o, issue_o, busy_o, var_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
           id_rd_i, id_wen_i, id_lat_i, id_var_i, flush_i, wb_clr_i, wb_rd_i,
    output stall_o, issue_o, busy_o, var_cnt_o
  );
endinterface

// File: rtl/id_scoreboard.sv
// Per-register pending-write scoreboard gating issue from ID into EX.
// stall_o/issue_o are same-cycle combinational from registered state; the decoder holds on stall.
module id_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int MAX_LAT  = 3,
  parameter int MAX_VAR  = 2
) (
  input  logic            clock,
  input  logic            reset,
  id_scoreboard_if.slave  sb
);
  localparam int LAT_W = $clog2(MAX_LAT + 1);
  localparam int VC_W  = $clog2(MAX_VAR + 1);

  logic [NUM_REGS-1:0]            busy_q, busy_d;
  logic [NUM_REGS-1:0]            var_q, var_d;
  logic [NUM_REGS-1:0][LAT_W-1:0] cnt_q, cnt_d;
  logic [VC_W-1:0]                var_cnt_q, var_cnt_d;

  logic hazard;
  logic live;
  logic issue;
  logic rd_wr;
  logic var_set;
  logic var_clr;

  always_comb begin
    hazard = (sb.id_use_rs1_i && (sb.id_rs1_i != '0) && busy_q[sb.id_rs1_i]) ||
             (sb.id_use_rs2_i && (sb.id_rs2_i != '0) && busy_q[sb.id_rs2_i]) ||
             (sb.id_wen_i && (sb.id_rd_i != '0) && var_q[sb.id_rd_i]) ||
             (sb.id_var_i && (var_cnt_q == VC_W'(MAX_VAR)));
    live   = sb.id_valid_i && !sb.flush_i;
    issue  = live && !hazard;
  end

  assign sb.stall_o   = live && hazard;
  assign sb.issue_o   = issue;
  assign sb.busy_o    = busy_q;
  assign sb.var_cnt_o = var_cnt_q;

  always_comb begin
    busy_d = busy_q;
    var_d  = var_q;
    cnt_d  = cnt_q;

    // Fixed-latency countdown; the 1->0 step frees the register at that edge.
    for (int r = 0; r < NUM_REGS; r++) begin
      if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - LAT_W'(1);
        if (cnt_q[r] == LAT_W'(1)) begin
          busy_d[r] = 1'b0;
        end
      end
    end

    var_clr = sb.wb_clr_i && (sb.wb_rd_i != '0) && var_q[sb.wb_rd_i];
    if (var_clr) begin
      busy_d[sb.wb_rd_i] = 1'b0;
      var_d[sb.wb_rd_i]  = 1'b0;
    end

    // Issue is applied last so a new producer overrides countdown and clear on the same rd.
    rd_wr   = issue && sb.id_wen_i && (sb.id_rd_i != '0);
    var_set = rd_wr && sb.id_var_i;
    if (rd_wr) begin
      if (sb.id_var_i) begin
        busy_d[sb.id_rd_i] = 1'b1;
        var_d[sb.id_rd_i]  = 1'b1;
        cnt_d[sb.id_rd_i]  = '0;
      end else begin
        busy_d[sb.id_rd_i] = (sb.id_lat_i != '0);
        var_d[sb.id_rd_i]  = 1'b0;
        cnt_d[sb.id_rd_i]  = sb.id_lat_i;
      end
    end

    var_cnt_d = var_cnt_q + VC_W'(var_set) - VC_W'(var_clr);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q    <= '0;
      var_q     <= '0;
      cnt_q     <= '0;
      var_cnt_q <= '0;
    end else begin
      busy_q    <= busy_d;
      var_q     <= var_d;
      cnt_q     <= cnt_d;
      var_cnt_q <= var_cnt_d;
    end
  end
endmodule

// File: tb/tb_id_scoreboard.sv
// Scoreboard bench: driver pushes expected outputs from a timestamp-based register model,
// a negedge monitor pops and compares them against the DUT.
module tb_id_scoreboard;
  localparam int NR = 32;
  localparam int MV = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  id_scoreboard_if sb_if ();
  id_scoreboard dut (.clock(clock), .reset(reset), .sb(sb_if));

  typedef struct {
    bit         v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    bit         u1;
    bit         u2;
    logic [4:0] rd;
    bit         wen;
    logic [1:0] lat;
    bit         isvar;
    bit         flush;
    bit         wclr;
    logic [4:0] wrd;
    bit         rst;
  } stim_t;

  typedef struct {
    bit          stall;
    bit          issue;
    logic [31:0] busy;
    int          vcnt;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t me;
  int   compared   = 0;
  int   mismatched = 0;

  // Model: a fixed producer makes its rd readable from cycle ready[r]; var producers pend until cleared.
  int ready[NR];
  bit vpend[NR];
  int vcnt;
  int cyc = 0;

  function automatic bit m_busy(int r);
    return (r != 0) && (vpend[r] || (cyc < ready[r]));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NR; i++) begin
      ready[i] = 0;
      vpend[i] = 1'b0;
    end
    vcnt = 0;
  endtask

  function automatic stim_t op(int rd, int rs1, int rs2, int lat, bit isvar);
    stim_t s;
    s = '{default: 0};
    s.v = 1'b1;
    s.u1 = 1'b1;
    s.u2 = 1'b1;
    s.wen = 1'b1;
    s.rd = 5'(rd);
    s.rs1 = 5'(rs1);
    s.rs2 = 5'(rs2);
    s.lat = 2'(lat);
    s.isvar = isvar;
    return s;
  endfunction

  function automatic stim_t clr(int wrd);
    stim_t s;
    s = '{default: 0};
    s.wclr = 1'b1;
    s.wrd = 5'(wrd);
    return s;
  endfunction

  task automatic run(input stim_t s);
    exp_t e;
    bit   haz;
    sb_if.id_valid_i   = s.v;
    sb_if.id_rs1_i     = s.rs1;
    sb_if.id_rs2_i     = s.rs2;
    sb_if.id_use_rs1_i = s.u1;
    sb_if.id_use_rs2_i = s.u2;
    sb_if.id_rd_i      = s.rd;
    sb_if.id_wen_i     = s.wen;
    sb_if.id_lat_i     = s.lat;
    sb_if.id_var_i     = s.isvar;
    sb_if.flush_i      = s.flush;
    sb_if.wb_clr_i     = s.wclr;
    sb_if.wb_rd_i      = s.wrd;
    reset              = s.rst;
    if (s.rst) model_clear();
    haz = (s.u1 && m_busy(int'(s.rs1))) || (s.u2 && m_busy(int'(s.rs2))) ||
          (s.wen && vpend[s.rd]) || (s.isvar && vcnt == MV);
    e.stall = s.v && !s.flush && haz;
    e.issue = s.v && !s.flush && !haz;
    for (int i = 0; i < NR; i++) e.busy[i] = m_busy(i);
    e.vcnt = vcnt;
    e.cyc  = cyc;
    exp_q.push_back(e);
    @(posedge clock);
    if (!s.rst) begin
      if (s.wclr && s.wrd != 0 && vpend[s.wrd]) begin
        vpend[s.wrd] = 1'b0;
        vcnt--;
      end
      if (e.issue && s.wen && s.rd != 0) begin
        if (s.isvar) begin
          vpend[s.rd] = 1'b1;
          ready[s.rd] = 0;
          vcnt++;
        end else begin
          ready[s.rd] = (s.lat == 0) ? 0 : cyc + int'(s.lat) + 1;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic chk(string name, int c, logic [31:0] got, logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, c, got, want);
    end
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      chk("stall_o", me.cyc, 32'(sb_if.stall_o), 32'(me.stall));
      chk("issue_o", me.cyc, 32'(sb_if.issue_o), 32'(me.issue));
      chk("busy_o", me.cyc, sb_if.busy_o, me.busy);
      chk("var_cnt_o", me.cyc, 32'(sb_if.var_cnt_o), 32'(me.vcnt));
    end
  end

  initial begin
    stim_t s;
    int    pend[$];
    model_clear();
    s = '{default: 0};
    @(posedge clock);
    #1;

    // Reset held with a valid instruction present.
    s = op(3, 1, 2, 0, 1'b0);
    s.rst = 1'b1;
    repeat (3) run(s);

    // Load-use: one stall, then issue.
    run(op(5, 0, 0, 1, 1'b0));
    repeat (2) run(op(6, 5, 1, 0, 1'b0));

    // Three-cycle mul: three stalls then issue.
    run(op(7, 0, 0, 3, 1'b0));
    repeat (4) run(op(12, 7, 0, 0, 1'b0));

    // Var limit: third div waits for a clear.
    run(op(8, 0, 0, 0, 1'b1));
    run(op(9, 0, 0, 0, 1'b1));
    repeat (2) run(op(11, 0, 0, 0, 1'b1));
    s = op(11, 0, 0, 0, 1'b1);
    s.wclr = 1'b1;
    s.wrd = 5'd8;
    run(s);
    run(op(11, 0, 0, 0, 1'b1));

    // WAW on a pending div, clears on non-var entries and x0 ignored.
    run(clr(9));
    run(clr(11));
    run(clr(12));
    run(clr(0));
    run(op(10, 0, 0, 0, 1'b1));
    repeat (2) run(op(10, 1, 2, 0, 1'b0));
    s = op(10, 1, 2, 0, 1'b0);
    s.wclr = 1'b1;
    s.wrd = 5'd10;
    run(s);
    run(op(10, 1, 2, 0, 1'b0));
    run(op(0, 0, 0, 3, 1'b0));
    run(op(0, 0, 0, 0, 1'b1));
    run(op(1, 0, 0, 0, 1'b0));

    // Flush of a stalled consumer keeps the producer entry.
    run(op(5, 0, 0, 2, 1'b0));
    s = op(6, 5, 0, 0, 1'b0);
    s.flush = 1'b1;
    run(s);
    repeat (2) run(op(6, 5, 0, 0, 1'b0));

    for (int i = 0; i < 3000; i++) begin
      s = '{default: 0};
      s.v     = ($urandom_range(0, 9) != 0);
      s.rs1   = 5'($urandom_range(0, 7));
      s.rs2   = 5'($urandom_range(0, 7));
      s.u1    = $urandom_range(0, 1) != 0;
      s.u2    = $urandom_range(0, 1) != 0;
      s.rd    = 5'($urandom_range(0, 7));
      s.wen   = ($urandom_range(0, 3) != 0);
      s.lat   = 2'($urandom_range(0, 3));
      s.isvar = ($urandom_range(0, 4) == 0);
      s.flush = ($urandom_range(0, 15) == 0);
      s.wclr  = ($urandom_range(0, 2) == 0);
      pend.delete();
      for (int r = 1; r < NR; r++) if (vpend[r]) pend.push_back(r);
      if (pend.size() > 0 && $urandom_range(0, 3) != 0)
        s.wrd = 5'(pend[$urandom_range(0, pend.size() - 1)]);
      else
        s.wrd = 5'($urandom_range(0, 7));
      s.rst   = ($urandom_range(0, 499) == 0);
      run(s);
    end

    s = '{default: 0};
    run(s);
    @(negedge clock);
    #1;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
